// File: rtl/contador_mod.sv
// Modulo up/down counter with prescaler, load, and saturate-or-wrap boundary handling.
// One-cycle latency: S and tc are registered; at_max and at_zero decode S combinationally.
module contador_mod #(
   parameter int WIDTH    = 3,
   parameter int MODULO   = 5,
   parameter int PRESCALE = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             up,
   input  logic             saturate,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] S,
   output logic             tc,
   output logic             at_max,
   output logic             at_zero
);

   localparam int               PCW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MODULO - 1);
   localparam logic [PCW-1:0]   PCMAX = PCW'(PRESCALE - 1);

   logic [WIDTH-1:0] r_s;
   logic [WIDTH-1:0] w_s_nxt;
   logic [PCW-1:0]   r_pc;
   logic [PCW-1:0]   w_pc_nxt;
   logic             r_tc;
   logic             w_tc_nxt;
   logic             w_step;

   assign w_step = enable && (r_pc == PCMAX);

   always_comb begin
      w_s_nxt  = r_s;
      w_pc_nxt = r_pc;
      w_tc_nxt = 1'b0;
      if (load) begin
         // Out-of-range loads clamp to the top of the count range.
         w_s_nxt  = (load_value > MAXV) ? MAXV : load_value;
         w_pc_nxt = '0;
      end else if (enable) begin
         if (w_step) begin
            w_pc_nxt = '0;
            if (up) begin
               if (r_s == MAXV) begin
                  if (!saturate) begin
                     w_s_nxt  = '0;
                     w_tc_nxt = 1'b1;
                  end
               end else begin
                  w_s_nxt = r_s + WIDTH'(1);
               end
            end else begin
               if (r_s == '0) begin
                  if (!saturate) begin
                     w_s_nxt  = MAXV;
                     w_tc_nxt = 1'b1;
                  end
               end else begin
                  w_s_nxt = r_s - WIDTH'(1);
               end
            end
         end else begin
            w_pc_nxt = r_pc + PCW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_s  <= '0;
         r_pc <= '0;
         r_tc <= 1'b0;
      end else begin
         r_s  <= w_s_nxt;
         r_pc <= w_pc_nxt;
         r_tc <= w_tc_nxt;
      end
   end

   assign S       = r_s;
   assign tc      = r_tc;
   assign at_max  = (r_s == MAXV);
   assign at_zero = (r_s == '0);

endmodule

// File: tb/tb_contador_mod.sv
// Directed bench: default counter driven from a vector table, plus
// prescale and full-range instances exercised by hand-written sequences.
module tb_contador_mod;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       up = 1'b1;
   logic       saturate = 1'b0;
   logic       load = 1'b0;
   logic [2:0] load_value = 3'd0;

   logic [2:0] s_a, s_b, s_c;
   logic       tc_a, tc_b, tc_c;
   logic       mx_a, mx_b, mx_c;
   logic       z_a, z_b, z_c;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   contador_mod #(.WIDTH(3), .MODULO(5), .PRESCALE(1)) u_a (
      .clock(clock), .reset(reset), .enable(enable), .up(up), .saturate(saturate),
      .load(load), .load_value(load_value),
      .S(s_a), .tc(tc_a), .at_max(mx_a), .at_zero(z_a));

   contador_mod #(.WIDTH(3), .MODULO(5), .PRESCALE(3)) u_b (
      .clock(clock), .reset(reset), .enable(enable), .up(up), .saturate(saturate),
      .load(load), .load_value(load_value),
      .S(s_b), .tc(tc_b), .at_max(mx_b), .at_zero(z_b));

   contador_mod #(.WIDTH(3), .MODULO(8), .PRESCALE(1)) u_c (
      .clock(clock), .reset(reset), .enable(enable), .up(up), .saturate(saturate),
      .load(load), .load_value(load_value),
      .S(s_c), .tc(tc_c), .at_max(mx_c), .at_zero(z_c));

   typedef struct {
      string      nm;
      logic       rst;
      logic       ld;
      logic [2:0] lv;
      logic       en;
      logic       up;
      logic       sat;
      logic [2:0] e_s;
      logic       e_tc;
      logic       e_max;
      logic       e_zero;
   } vec_t;

   vec_t vec[$];

   function automatic vec_t mk(string nm, logic rst, logic ld, logic [2:0] lv,
                               logic en, logic u, logic sat,
                               logic [2:0] s, logic t, logic mx, logic z);
      vec_t v;
      v.nm = nm; v.rst = rst; v.ld = ld; v.lv = lv; v.en = en; v.up = u; v.sat = sat;
      v.e_s = s; v.e_tc = t; v.e_max = mx; v.e_zero = z;
      return v;
   endfunction

   task automatic chk(string nm, int idx, logic [7:0] act, logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
      end
   endtask

   task automatic drive(logic rst, logic ld, logic [2:0] lv, logic en, logic u, logic sat);
      reset = rst; load = ld; load_value = lv; enable = en; up = u; saturate = sat;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int up_seq[12] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};
      int dn_seq[5]  = '{3, 2, 1, 0, 0};
      int cnt_seq[3] = '{1, 2, 3};
      int b_seq[9]   = '{0, 0, 1, 1, 1, 2, 2, 2, 3};

      // name, rst, ld, lv, en, up, sat, S, tc, at_max, at_zero
      vec.push_back(mk("reset", 1, 0, 0, 0, 1, 0, 0, 0, 0, 1));
      foreach (up_seq[i])
         vec.push_back(mk("up_wrap", 0, 0, 0, 1, 1, 0, 3'(up_seq[i]),
                          up_seq[i] == 0, up_seq[i] == 4, up_seq[i] == 0));
      vec.push_back(mk("load4", 0, 1, 4, 0, 1, 1, 4, 0, 1, 0));
      for (int i = 0; i < 3; i++)
         vec.push_back(mk("sat_up", 0, 0, 0, 1, 1, 1, 4, 0, 1, 0));
      foreach (dn_seq[i])
         vec.push_back(mk("sat_down", 0, 0, 0, 1, 0, 1, 3'(dn_seq[i]), 0, 0, dn_seq[i] == 0));
      vec.push_back(mk("wrap_down", 0, 0, 0, 1, 0, 0, 4, 1, 1, 0));
      vec.push_back(mk("clamp_load", 0, 1, 7, 0, 0, 0, 4, 0, 1, 0));
      vec.push_back(mk("hold_dis", 0, 0, 0, 0, 1, 0, 4, 0, 1, 0));
      vec.push_back(mk("rst_and_ld", 1, 1, 2, 1, 1, 0, 0, 0, 0, 1));
      foreach (cnt_seq[i])
         vec.push_back(mk("count", 0, 0, 0, 1, 1, 0, 3'(cnt_seq[i]), 0, 0, 0));
      vec.push_back(mk("rst_mid", 1, 0, 0, 1, 1, 0, 0, 0, 0, 1));
      vec.push_back(mk("after_rst", 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));

      foreach (vec[i]) begin
         drive(vec[i].rst, vec[i].ld, vec[i].lv, vec[i].en, vec[i].up, vec[i].sat);
         tick();
         chk({vec[i].nm, ".S"},       i, 8'(s_a),  8'(vec[i].e_s));
         chk({vec[i].nm, ".tc"},      i, 8'(tc_a), 8'(vec[i].e_tc));
         chk({vec[i].nm, ".at_max"},  i, 8'(mx_a), 8'(vec[i].e_max));
         chk({vec[i].nm, ".at_zero"}, i, 8'(z_a),  8'(vec[i].e_zero));
      end

      // Prescale by 3: steps on every third enabled edge.
      drive(1, 0, 0, 0, 1, 0);
      tick();
      chk("pre_reset.S", 0, 8'(s_b), 8'd0);
      chk("pre_reset.tc", 0, 8'(tc_b), 8'd0);
      foreach (b_seq[i]) begin
         drive(0, 0, 0, 1, 1, 0);
         tick();
         chk("pre_step.S", i, 8'(s_b), 8'(b_seq[i]));
      end
      // Two disabled edges mid-prescale delay the step by exactly two edges.
      drive(0, 0, 0, 1, 1, 0); tick(); chk("pre_gap.S", 0, 8'(s_b), 8'd3);
      drive(0, 0, 0, 0, 1, 0); tick(); chk("pre_gap.S", 1, 8'(s_b), 8'd3);
      drive(0, 0, 0, 0, 1, 0); tick(); chk("pre_gap.S", 2, 8'(s_b), 8'd3);
      drive(0, 0, 0, 1, 1, 0); tick(); chk("pre_gap.S", 3, 8'(s_b), 8'd3);
      drive(0, 0, 0, 1, 1, 0); tick(); chk("pre_gap.S", 4, 8'(s_b), 8'd4);
      // Reset mid-prescale discards the partial count.
      drive(0, 0, 0, 1, 1, 0); tick(); chk("pre_part.S", 0, 8'(s_b), 8'd4);
      drive(1, 0, 0, 1, 1, 0); tick(); chk("pre_rst.S", 0, 8'(s_b), 8'd0);
      drive(0, 0, 0, 1, 1, 0); tick(); chk("pre_rst.S", 1, 8'(s_b), 8'd0);
      drive(0, 0, 0, 1, 1, 0); tick(); chk("pre_rst.S", 2, 8'(s_b), 8'd0);
      drive(0, 0, 0, 1, 1, 0); tick(); chk("pre_rst.S", 3, 8'(s_b), 8'd1);

      // Full binary range: MODULO == 2^WIDTH wraps through 7 and 0.
      drive(0, 1, 7, 0, 1, 0); tick();
      chk("full_ld.S", 0, 8'(s_c), 8'd7);
      chk("full_ld.at_max", 0, 8'(mx_c), 8'd1);
      drive(0, 0, 0, 1, 1, 0); tick();
      chk("full_up.S", 0, 8'(s_c), 8'd0);
      chk("full_up.tc", 0, 8'(tc_c), 8'd1);
      chk("full_up.at_zero", 0, 8'(z_c), 8'd1);
      drive(0, 0, 0, 1, 0, 0); tick();
      chk("full_dn.S", 0, 8'(s_c), 8'd7);
      chk("full_dn.tc", 0, 8'(tc_c), 8'd1);
      drive(0, 0, 0, 1, 0, 0); tick();
      chk("full_dn.S", 1, 8'(s_c), 8'd6);
      chk("full_dn.tc", 1, 8'(tc_c), 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
